// File: rtl/sequence_scan_ctrl_if.sv
// sequence_scan_ctrl_if: word, pattern and result signals of the sequence scanner.
// sat_flag exists only when SEQ_SCAN_SAT_EN is defined.
interface sequence_scan_ctrl_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W = 8
);
    logic [WORD_W-1:0] word_in;
    logic word_valid;
    logic word_ready;
    logic [3:0] pattern_in;
    logic pattern_load;
    logic count_clear;
    logic busy;
    logic hit;
    logic done;
    logic [CNT_W-1:0] hit_count;
`ifdef SEQ_SCAN_SAT_EN
    logic sat_flag;
`endif
    modport master (
        output word_in, word_valid, pattern_in, pattern_load, count_clear,
        input word_ready, busy, hit, done, hit_count
`ifdef SEQ_SCAN_SAT_EN
        , input sat_flag
`endif
    );
    modport slave (
        input word_in, word_valid, pattern_in, pattern_load, count_clear,
        output word_ready, busy, hit, done, hit_count
`ifdef SEQ_SCAN_SAT_EN
        , output sat_flag
`endif
    );
endinterface

// File: rtl/sequence_scan_ctrl.sv
// sequence_scan_ctrl: shifts each accepted word out MSB first and counts overlapping 4-bit pattern matches.
// Define SEQ_SCAN_SAT_EN for a saturating hit_count with sticky sat_flag; otherwise hit_count wraps.
module sequence_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic reset,
    sequence_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int KW = $clog2(WORD_W + 1);
    state_t state, state_nx;
    logic [WORD_W-1:0] sreg;
    logic [KW-1:0] k;
    logic [3:0] hist, hist_nx, pattern;
    logic [2:0] hist_cnt;
    logic accept, match, inc;
    always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
    // Match looks at the history including the bit shifted this cycle, so hit lands one cycle later.
    always_comb begin
        accept = bus.word_valid && state == IDLE;
        hist_nx = {hist[2:0], sreg[WORD_W-1]};
        match = hist_cnt >= 3'd3 && hist_nx == pattern;
        inc = state == SHIFT && match;
        state_nx = state == IDLE ? (accept ? SHIFT : IDLE)
                 : state == SHIFT ? (k == KW'(WORD_W) ? DONE : SHIFT)
                 : IDLE;
        bus.word_ready = state == IDLE;
        bus.busy = state == SHIFT || state == DONE;
        bus.done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            k <= '0;
            hist <= '0;
            hist_cnt <= '0;
            pattern <= 4'b0100;
            bus.hit <= 1'b0;
            bus.hit_count <= '0;
`ifdef SEQ_SCAN_SAT_EN
            bus.sat_flag <= 1'b0;
`endif
        end else begin
            bus.hit <= inc;
            if (accept) begin
                sreg <= bus.word_in;
                k <= KW'(1);
            end else if (state == SHIFT) begin
                sreg <= sreg << 1;
                k <= k + 1'b1;
                hist <= hist_nx;
                hist_cnt <= hist_cnt == 3'd4 ? hist_cnt : hist_cnt + 3'd1;
            end
            // A load coinciding with an accept is dropped.
            if (state == IDLE && !accept && bus.pattern_load) begin
                pattern <= bus.pattern_in;
                hist_cnt <= '0;
            end
`ifdef SEQ_SCAN_SAT_EN
            if (bus.count_clear) begin
                bus.hit_count <= '0;
                bus.sat_flag <= 1'b0;
            end else if (inc && &bus.hit_count)
                bus.sat_flag <= 1'b1;
            else if (inc)
                bus.hit_count <= bus.hit_count + 1'b1;
`else
            if (bus.count_clear)
                bus.hit_count <= '0;
            else if (inc)
                bus.hit_count <= bus.hit_count + 1'b1;
`endif
        end
    end
endmodule
